mem_arbiter: RTL and testbench

- Sequential arbiter that shares the single-ported RAM between the instruction-fetch path (iREN/iaddr) and the data path (dREN/dWEN/daddr).
- The data path is driven by the control unit's dREN/dWEN outputs.
- Sits between the datapath/caches and the RAM model.
- Features: data-priority grant FSM, instruction anti-starvation counter, access timeout and error reporting.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data has priority; a streak counter forces an instruction grant to prevent starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;
  localparam logic [3:0]  STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0]  TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        dreq;
  logic        abort;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + 4'd1;
  endfunction

  assign dreq  = dREN | dWEN;
  assign abort = (ramstate == RAM_ERROR) || (tcnt_q == TCNT_LAST);

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    tcnt_d     = tcnt_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    iwait      = iREN;
    dwait      = dreq;
    merr       = 1'b0;

    case (state_q)
      IDLE: begin
        tcnt_d = 8'd0;
        if (dreq && !(iREN && streak_q == STREAK_MAX)) state_d = DGRANT;
        else if (iREN)                                 state_d = IGRANT;
      end

      DGRANT: begin
        ramaddr_d  = daddr;
        ramstore_d = dstore;
        if (!dreq) begin
          state_d = IDLE;
          tcnt_d  = 8'd0;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait    = 1'b0;
            dload_d  = ramload;
            state_d  = IDLE;
            tcnt_d   = 8'd0;
            streak_d = iREN ? sat_inc(streak_q) : 4'd0;
          end else if (abort) begin
            dwait    = 1'b0;
            dload_d  = ERR_WORD;
            merr     = 1'b1;
            state_d  = IDLE;
            tcnt_d   = 8'd0;
            streak_d = 4'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end

      IGRANT: begin
        ramaddr_d = iaddr;
        if (!iREN) begin
          state_d = IDLE;
          tcnt_d  = 8'd0;
        end else begin
          ramREN = 1'b1;
          if (ramstate == RAM_ACCESS || abort) begin
            iwait    = 1'b0;
            iload_d  = (ramstate == RAM_ACCESS) ? ramload : ERR_WORD;
            merr     = (ramstate != RAM_ACCESS);
            state_d  = IDLE;
            tcnt_d   = 8'd0;
            streak_d = 4'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A reset cycle never completes or aborts anything and never drives the RAM.
    if (RST) begin
      ramREN  = 1'b0;
      ramWEN  = 1'b0;
      merr    = 1'b0;
      iwait   = iREN;
      dwait   = dreq;
      iload_d = iload_q;
      dload_d = dload_q;
    end
  end

  assign ramaddr  = ramaddr_d;
  assign ramstore = ramstore_d;
  assign iload    = iload_d;
  assign dload    = dload_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      tcnt_q     <= 8'd0;
      ramaddr_q  <= 32'd0;
      ramstore_q <= 32'd0;
      iload_q    <= 32'd0;
      dload_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tcnt_q     <= tcnt_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int          LIMIT = 4;
  localparam int          TMO   = 8;
  localparam logic [31:0] BAD   = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramstate = FREE; ramload = 32'h0;
    next(); next();
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, merr, iwait, dwait} !== 5'b00010) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", {ramREN, ramWEN, merr, iwait, dwait}, 5'b00010);
    end
    checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all zero", ramaddr, ramstore, iload, dload);
    end
    next();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      errors++; $display("FAIL t1_idle: got ren=%b iwait=%b expected ren=0 iwait=1", ramREN, iwait);
    end
    next();
    ramstate = BUSY;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
      errors++; $display("FAIL t1_igrant: got ren=%b wen=%b addr=%h iwait=%b expected 1 0 00000040 1", ramREN, ramWEN, ramaddr, iwait);
    end
    next();
    ramstate = ACCESS; ramload = 32'h3C010004;
    @(negedge CLK);
    checks++;
    if (iwait !== 1'b0 || iload !== 32'h3C010004 || merr !== 1'b0) begin
      errors++; $display("FAIL t1_complete: got iwait=%b iload=%h merr=%b expected 0 3c010004 0", iwait, iload, merr);
    end
    next();
    ramstate = FREE; ramload = 32'h0;
    @(negedge CLK);
    checks++;
    if (iwait !== 1'b1 || ramREN !== 1'b0 || iload !== 32'h3C010004) begin
      errors++; $display("FAIL t1_after: got iwait=%b ren=%b iload=%h expected 1 0 3c010004", iwait, ramREN, iload);
    end
    next();
    iREN = 1'b0;
    next(); next();
  endtask

  task automatic test_data_priority();
    iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin
      errors++; $display("FAIL t2_idle: got ren=%b wen=%b expected 0 0", ramREN, ramWEN);
    end
    next();
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF || dwait !== 1'b1) begin
      errors++; $display("FAIL t2_dgrant: got wen=%b ren=%b addr=%h st=%h dwait=%b", ramWEN, ramREN, ramaddr, ramstore, dwait);
    end
    next();
    ramstate = ACCESS;
    @(negedge CLK);
    checks++;
    if (dwait !== 1'b0 || iwait !== 1'b1 || ramWEN !== 1'b1) begin
      errors++; $display("FAIL t2_dcomplete: got dwait=%b iwait=%b wen=%b expected 0 1 1", dwait, iwait, ramWEN);
    end
    next();
    dWEN = 1'b0; ramstate = BUSY;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_idle_hold: got ren=%b wen=%b addr=%h st=%h", ramREN, ramWEN, ramaddr, ramstore);
    end
    next();
    ramstate = ACCESS; ramload = 32'h11;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b0 || iload !== 32'h11) begin
      errors++; $display("FAIL t2_igrant: got ren=%b addr=%h iwait=%b iload=%h", ramREN, ramaddr, iwait, iload);
    end
    next();
    iREN = 1'b0; ramstate = FREE;
    next();
  endtask

  task automatic test_starvation();
    int  dcount = 0;
    bit  idone  = 1'b0;
    iREN = 1'b1; iaddr = 32'h900; dREN = 1'b1; daddr = 32'h800; ramstate = ACCESS;
    for (int c = 0; c < 40 && !idone; c++) begin
      ramload = $urandom;
      @(negedge CLK);
      if (dwait === 1'b0) begin
        dcount++;
        checks++;
        if (dload !== ramload || ramaddr !== 32'h800) begin
          errors++; $display("FAIL t3_dload: got %h addr=%h expected %h addr=00000800", dload, ramaddr, ramload);
        end
      end
      if (iwait === 1'b0) idone = 1'b1;
      else next();
    end
    checks++;
    if (!idone || dcount != LIMIT) begin
      errors++; $display("FAIL t3_streak: got %0d data completions (instr done=%0d) expected %0d then instr", dcount, idone, LIMIT);
    end
    next();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0) begin
      errors++; $display("FAIL t3_idle: got ren=%b expected 0", ramREN);
    end
    next();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h800 || dwait !== 1'b0) begin
      errors++; $display("FAIL t3_cleared: got ren=%b addr=%h dwait=%b expected 1 00000800 0", ramREN, ramaddr, dwait);
    end
    next();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    next();
  endtask

  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    @(negedge CLK);
    next();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLK);
      checks++;
      if (merr !== (k == TMO) || dwait !== (k != TMO)) begin
        errors++; $display("FAIL t4_cycle%0d: got merr=%b dwait=%b expected %b %b", k, merr, dwait, k == TMO, k != TMO);
      end
      if (k == TMO) begin
        checks++;
        if (dload !== BAD) begin
          errors++; $display("FAIL t4_dload: got %h expected %h", dload, BAD);
        end
      end
      next();
    end
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || merr !== 1'b0) begin
      errors++; $display("FAIL t4_idle: got ren=%b merr=%b expected 0 0", ramREN, merr);
    end
    next();
    dREN = 1'b0; ramstate = FREE;
    next();
  endtask

  task automatic test_error_withdraw();
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    next();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || merr !== 1'b0) begin
      errors++; $display("FAIL t5_igrant: got ren=%b merr=%b expected 1 0", ramREN, merr);
    end
    next();
    ramstate = ERROR;
    @(negedge CLK);
    checks++;
    if (merr !== 1'b1 || iwait !== 1'b0 || iload !== BAD) begin
      errors++; $display("FAIL t5_error: got merr=%b iwait=%b iload=%h expected 1 0 %h", merr, iwait, iload, BAD);
    end
    next();
    iREN = 1'b0; ramstate = FREE;
    next();
    dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
    next();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin
      errors++; $display("FAIL t5_dgrant: got ren=%b addr=%h expected 1 00000600", ramREN, ramaddr);
    end
    next();
    dREN = 1'b0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || merr !== 1'b0 || dwait !== 1'b0) begin
      errors++; $display("FAIL t5_withdraw: got ren=%b merr=%b dwait=%b expected 0 0 0", ramREN, merr, dwait);
    end
    next();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || merr !== 1'b0) begin
      errors++; $display("FAIL t5_after: got ren=%b merr=%b expected 0 0", ramREN, merr);
    end
    next();
  endtask

  task automatic test_reset_mid_grant();
    dREN = 1'b1; daddr = 32'h700; dstore = 32'h77; ramstate = BUSY;
    next();
    next();
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || merr !== 1'b0) begin
      errors++; $display("FAIL t6_rst_cycle: got ren=%b wen=%b merr=%b expected 0 0 0", ramREN, ramWEN, merr);
    end
    next();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0 || merr !== 1'b0 || dload !== 32'h0) begin
      errors++; $display("FAIL t6_after: got ren=%b wen=%b addr=%h st=%h merr=%b dload=%h", ramREN, ramWEN, ramaddr, ramstore, merr, dload);
    end
    next();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLK);
      checks++;
      if (merr !== (k == TMO)) begin
        errors++; $display("FAIL t6_tcnt%0d: got merr=%b expected %b", k, merr, k == TMO);
      end
      next();
    end
    dREN = 1'b0; ramstate = FREE;
    next();
  endtask

  task automatic test_random();
    int          mg, mw, ms, nxt, r;
    logic [31:0] m_addr, m_store, m_il, m_dl, e_addr, e_store;
    logic        e_ren, e_wen, e_merr, e_iwait, e_dwait, ddone, idone, dq;
    logic        d_act, i_act, pdw, piw, wd;
    mg = 0; mw = 0; ms = 0;
    m_addr = '0; m_store = '0; m_il = '0; m_dl = '0;
    d_act = 1'b0; i_act = 1'b0; pdw = 1'b0; piw = 1'b0;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    next();
    RST = 1'b0;
    for (int c = 0; c < 600; c++) begin
      wd = 1'b0;
      if (d_act && !pdw) d_act = 1'b0;
      else if (d_act && $urandom_range(99) < 2) begin d_act = 1'b0; wd = 1'b1; end
      if (!d_act && !wd && $urandom_range(99) < 45) begin
        d_act = 1'b1;
        r = $urandom_range(3);
        dREN = (r != 1); dWEN = (r == 1 || r == 2);
        daddr = $urandom; dstore = $urandom;
      end
      if (!d_act) begin dREN = 1'b0; dWEN = 1'b0; end
      wd = 1'b0;
      if (i_act && !piw) i_act = 1'b0;
      else if (i_act && $urandom_range(99) < 2) begin i_act = 1'b0; wd = 1'b1; end
      if (!i_act && !wd && $urandom_range(99) < 45) begin
        i_act = 1'b1; iaddr = $urandom;
      end
      iREN = i_act;
      r = $urandom_range(99);
      ramstate = (r < 30) ? ACCESS : (r < 35) ? ERROR : (r < 65) ? BUSY : FREE;
      ramload = $urandom;
      @(negedge CLK);
      // Reference: who owns the RAM, how long it has waited, how many data wins in a row.
      dq = dREN | dWEN;
      e_ren = 0; e_wen = 0; e_merr = 0; ddone = 0; idone = 0;
      e_addr = m_addr; e_store = m_store; nxt = mg;
      if (mg == 0) begin
        mw = 0;
        if (dq && !(iREN && ms == LIMIT)) nxt = 1;
        else if (iREN) nxt = 2;
      end else if (mg == 1) begin
        e_addr = daddr; e_store = dstore;
        if (!dq) begin nxt = 0; mw = 0; end
        else begin
          e_wen = dWEN; e_ren = dREN && !dWEN;
          if (ramstate == ACCESS) begin
            ddone = 1; m_dl = ramload; nxt = 0; mw = 0;
            ms = iREN ? ((ms + 1 > LIMIT) ? LIMIT : ms + 1) : 0;
          end else if (ramstate == ERROR || mw == TMO - 1) begin
            ddone = 1; m_dl = BAD; e_merr = 1; nxt = 0; mw = 0; ms = 0;
          end else mw++;
        end
      end else begin
        e_addr = iaddr;
        if (!iREN) begin nxt = 0; mw = 0; end
        else begin
          e_ren = 1;
          if (ramstate == ACCESS) begin
            idone = 1; m_il = ramload; nxt = 0; mw = 0; ms = 0;
          end else if (ramstate == ERROR || mw == TMO - 1) begin
            idone = 1; m_il = BAD; e_merr = 1; nxt = 0; mw = 0; ms = 0;
          end else mw++;
        end
      end
      m_addr = e_addr; m_store = e_store; mg = nxt;
      e_iwait = iREN && !idone;
      e_dwait = dq && !ddone;
      checks++;
      if ({ramREN, ramWEN, merr, iwait, dwait} !== {e_ren, e_wen, e_merr, e_iwait, e_dwait}) begin
        errors++; $display("FAIL rnd_ctrl c=%0d: got ren,wen,merr,iwait,dwait=%b expected %b", c, {ramREN, ramWEN, merr, iwait, dwait}, {e_ren, e_wen, e_merr, e_iwait, e_dwait});
      end
      checks++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        errors++; $display("FAIL rnd_ram c=%0d: got addr=%h st=%h expected addr=%h st=%h", c, ramaddr, ramstore, e_addr, e_store);
      end
      checks++;
      if (iload !== m_il || dload !== m_dl) begin
        errors++; $display("FAIL rnd_load c=%0d: got iload=%h dload=%h expected %h %h", c, iload, dload, m_il, m_dl);
      end
      pdw = e_dwait; piw = e_iwait;
      next();
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    next();
  endtask

  initial begin
    test_reset();
    test_data_priority();
    test_starvation();
    test_timeout();
    test_error_withdraw();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
